pipeline_register: RTL



---
 rtl/pipeline_register_pkg.sv | 18 +
 rtl/pipeline_register_if.sv | 36 +++
 rtl/pipe_stage.sv | 61 ++++++
 rtl/pipeline_register.sv | 111 +++++++++++
 4 files changed

// File: rtl/pipeline_register_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_register_pkg
// Shared definitions for the pipeline_register block and its bench:
//   DEFAULT_N      default data width
//   DEFAULT_DEPTH  default number of register stages
//   occ_width()    width of the optional occupancy counter (PIPE_OCCUPANCY_EN)
// -----------------------------------------------------------------------------
package pipeline_register_pkg;

   localparam int DEFAULT_N     = 16;
   localparam int DEFAULT_DEPTH = 3;

   // Bits needed to count 0..depth words held in the pipe.
   function automatic int occ_width(input int depth);
      return (depth < 1) ? 1 : $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/pipeline_register_if.sv
// -----------------------------------------------------------------------------
// pipeline_register_if
// Upstream and downstream handshake bundle of pipeline_register.
//   in_data / in_valid / in_ready     upstream side (producer -> pipe)
//   out_data / out_valid / out_ready  downstream side (pipe -> consumer)
// Modports:
//   master  the environment (drives in_*, out_ready)
//   slave   the pipeline    (drives in_ready, out_*)
//
// Handshake: a word moves across a side on a rising edge where valid and
// ready are both 1. The sender holds data stable while valid = 1 and
// ready = 0; ready may depend combinationally on the receiver's state and on
// the downstream ready, never on the same side's valid.
// -----------------------------------------------------------------------------
interface pipeline_register_if
   import pipeline_register_pkg::*;
   #(parameter int N = DEFAULT_N);

   logic [N-1:0] in_data;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] out_data;
   logic         out_valid;
   logic         out_ready;

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid
   );

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid
   );

endinterface

// File: rtl/pipe_stage.sv
// -----------------------------------------------------------------------------
// pipe_stage
// One data/valid register pair of the pipeline_register chain.
// Ports:
//   clk      clock, rising edge
//   rst      synchronous active-high reset: valid and data cleared
//   flush_i  synchronous clear of valid only (data kept)
//   load_i   stage may take the upstream word this cycle
//   data_i   upstream data
//   valid_i  upstream valid
//   data_o   registered data
//   valid_o  registered valid
// Priority: rst > flush_i > load_i.
// -----------------------------------------------------------------------------
module pipe_stage
   import pipeline_register_pkg::*;
   #(parameter int N = DEFAULT_N)
   (
      input  logic         clk,
      input  logic         rst,
      input  logic         flush_i,
      input  logic         load_i,
      input  logic [N-1:0] data_i,
      input  logic         valid_i,
      output logic [N-1:0] data_o,
      output logic         valid_o
   );

   logic [N-1:0] data_q;
   logic [N-1:0] data_d;
   logic         valid_q;
   logic         valid_d;

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      if (flush_i) begin
         valid_d = 1'b0;
      end else if (load_i) begin
         valid_d = valid_i;
         // Bubbles pass through the valid bit only; data holds its last word.
         if (valid_i) begin
            data_d = data_i;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign data_o  = data_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/pipeline_register.sv
// -----------------------------------------------------------------------------
// pipeline_register
// DEPTH-deep, N-bit register chain with valid/ready on both sides, per-stage
// bubble collapsing and a synchronous flush. Unstalled latency is DEPTH
// cycles at one word per cycle; a full pipe holds DEPTH words.
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset (all stages emptied, data zeroed)
//   flush      synchronous clear of all valid bits (data kept); the word
//              presented on the flush cycle is dropped
//   bus        pipeline_register_if.slave: in_data/in_valid/in_ready,
//              out_data/out_valid/out_ready
//   occupancy  (only with PIPE_OCCUPANCY_EN) number of valid stages
// Optional feature macro: PIPE_OCCUPANCY_EN.
// -----------------------------------------------------------------------------
module pipeline_register
   import pipeline_register_pkg::*;
   #(
      parameter int N     = DEFAULT_N,
      parameter int DEPTH = DEFAULT_DEPTH
   )
   (
      input  logic clk,
      input  logic rst,
      input  logic flush,
      pipeline_register_if.slave bus
`ifdef PIPE_OCCUPANCY_EN
      ,
      output logic [occ_width(DEPTH)-1:0] occupancy
`endif
   );

   logic [N-1:0]     stage_data [DEPTH];
   logic [DEPTH-1:0] stage_valid;
   logic [DEPTH-1:0] ready;

   // A stage may load when it or any stage downstream of it is empty, or the
   // consumer takes the last word this cycle. Written as a reduction over the
   // downstream slice instead of a bit-to-bit chain; the function is the same.
   for (genvar i = 0; i < DEPTH; i++) begin : g_ready
      assign ready[i] = ~(&stage_valid[DEPTH-1:i]) | bus.out_ready;
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic [N-1:0] up_data;
      logic         up_valid;

      if (i == 0) begin : g_head
         assign up_data  = bus.in_data;
         assign up_valid = bus.in_valid;
      end else begin : g_body
         assign up_data  = stage_data[i-1];
         assign up_valid = stage_valid[i-1];
      end

      pipe_stage #(.N(N)) u_stage (
         .clk     (clk),
         .rst     (rst),
         .flush_i (flush),
         .load_i  (ready[i]),
         .data_i  (up_data),
         .valid_i (up_valid),
         .data_o  (stage_data[i]),
         .valid_o (stage_valid[i])
      );
   end

   // in_ready is forced low during reset so nothing is taken on a reset edge.
   assign bus.in_ready  = ready[0] & ~rst;
   assign bus.out_data  = stage_data[DEPTH-1];
   assign bus.out_valid = stage_valid[DEPTH-1];

`ifdef PIPE_OCCUPANCY_EN
   localparam int OCC_W = occ_width(DEPTH);

   logic [OCC_W-1:0] occ_q;
   logic [OCC_W-1:0] occ_d;
   logic             in_xfer;
   logic             out_xfer;

   assign in_xfer  = bus.in_valid & bus.in_ready;
   assign out_xfer = bus.out_valid & bus.out_ready;

   always_comb begin
      occ_d = occ_q;
      if (flush) begin
         occ_d = '0;
      end else if (in_xfer & ~out_xfer) begin
         occ_d = occ_q + OCC_W'(1);
      end else if (out_xfer & ~in_xfer) begin
         occ_d = occ_q - OCC_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         occ_q <= '0;
      end else begin
         occ_q <= occ_d;
      end
   end

   assign occupancy = occ_q;

   // The counter is a cheap registered mirror of the popcount of the valid bits.
   occupancy_matches_valid : assert property (
      @(posedge clk) disable iff (rst) occ_q == OCC_W'($countones(stage_valid))
   );
`endif

endmodule
